// File: rtl/xif_mem_responder.sv
// CORE-V-XIF memory responder: alignment check, speculative request queue, single-outstanding OBI data port.
// Latency: a committed request into an empty queue drives dmem_req the next cycle; the result comes one cycle after rvalid.
// Backpressure: mem_ready drops while the queue is full, with no dependence on a same-cycle pop; dmem_req is held until dmem_gnt.
module xif_mem_responder #(
    parameter int X_ID_WIDTH  = 4,
    parameter int X_MEM_WIDTH = 32,
    parameter int QUEUE_DEPTH = 2
) (
    input  logic                     ck,
    input  logic                     rst_n,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [X_ID_WIDTH-1:0]    mem_req_id,
    input  logic [31:0]              mem_req_addr,
    input  logic                     mem_req_we,
    input  logic [2:0]               mem_req_size,
    input  logic [X_MEM_WIDTH/8-1:0] mem_req_be,
    input  logic [X_MEM_WIDTH-1:0]   mem_req_wdata,
    input  logic                     mem_req_spec,
    output logic                     mem_resp_exc,
    output logic [5:0]               mem_resp_exccode,
    input  logic                     commit_valid,
    input  logic [X_ID_WIDTH-1:0]    commit_id,
    input  logic                     commit_kill,
    output logic                     dmem_req,
    input  logic                     dmem_gnt,
    output logic [31:0]              dmem_addr,
    output logic                     dmem_we,
    output logic [X_MEM_WIDTH/8-1:0] dmem_be,
    output logic [X_MEM_WIDTH-1:0]   dmem_wdata,
    input  logic                     dmem_rvalid,
    input  logic [X_MEM_WIDTH-1:0]   dmem_rdata,
    input  logic                     dmem_err,
    output logic                     mem_result_valid,
    output logic [X_ID_WIDTH-1:0]    mem_result_id,
    output logic [X_MEM_WIDTH-1:0]   mem_result_rdata,
    output logic                     mem_result_err
);
    localparam int BE_W  = X_MEM_WIDTH / 8;
    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(QUEUE_DEPTH - 1);

    typedef struct packed {
        logic [X_ID_WIDTH-1:0]  id;
        logic [31:0]            addr;
        logic                   we;
        logic [BE_W-1:0]        be;
        logic [X_MEM_WIDTH-1:0] wdata;
        logic                   committed;
        logic                   killed;
    } ent_t;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    ent_t                   q_dat [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] q_vld;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    state_t                 state;
    state_t                 state_nxt;
    logic [X_ID_WIDTH-1:0]  cur_id;

    logic misaligned;
    logic q_full;
    logic q_empty;
    logic push_vld;
    logic new_hit;
    logic enq;
    logic pop;
    logic bypass;
    logic issue;
    ent_t new_ent;
    ent_t head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign misaligned = (mem_req_size == 3'd1 && mem_req_addr[0]) ||
                        (mem_req_size == 3'd2 && mem_req_addr[1:0] != 2'b00) ||
                        (mem_req_size > 3'd2);

    assign mem_resp_exc     = mem_valid && misaligned;
    assign mem_resp_exccode = !mem_resp_exc ? 6'd0 : (mem_req_we ? 6'd6 : 6'd4);

    // Full is a pure function of stored state, so a pop never opens mem_ready in the same cycle.
    assign q_full    = q_vld[wr_ptr];
    assign q_empty   = !q_vld[rd_ptr];
    assign mem_ready = rst_n && !q_full;
    assign push_vld  = mem_valid && mem_ready && !misaligned;

    // A commit for the id being accepted this cycle lands on the new entry.
    assign new_hit = commit_valid && (commit_id == mem_req_id);
    always_comb begin
        new_ent           = '0;
        new_ent.id        = mem_req_id;
        new_ent.addr      = mem_req_addr;
        new_ent.we        = mem_req_we;
        new_ent.be        = mem_req_be;
        new_ent.wdata     = mem_req_wdata;
        new_ent.committed = !mem_req_spec || (new_hit && !commit_kill);
        new_ent.killed    = new_hit && commit_kill;
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // With an empty queue in IDLE the incoming request is decided directly, skipping the queue.
    always_comb begin
        state_nxt = state;
        head      = q_dat[rd_ptr];
        pop       = 1'b0;
        bypass    = 1'b0;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (!q_empty) begin
                    if (head.killed) begin
                        pop = 1'b1;
                    end else if (head.committed) begin
                        pop       = 1'b1;
                        issue     = 1'b1;
                        state_nxt = REQ;
                    end
                end else if (push_vld) begin
                    head = new_ent;
                    if (new_ent.killed) begin
                        bypass = 1'b1;
                    end else if (new_ent.committed) begin
                        bypass    = 1'b1;
                        issue     = 1'b1;
                        state_nxt = REQ;
                    end
                end
            end
            REQ:     if (dmem_gnt) state_nxt = WAIT;
            WAIT:    if (dmem_rvalid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign enq = push_vld && !bypass;

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            q_vld  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (enq) begin
                q_vld[wr_ptr] <= 1'b1;
                wr_ptr        <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                q_vld[rd_ptr] <= 1'b0;
                rd_ptr        <= ptr_inc(rd_ptr);
            end
        end
    end

    // Payload storage needs no reset: every read is qualified by q_vld.
    always_ff @(posedge ck) begin
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if (q_vld[i] && commit_valid && q_dat[i].id == commit_id) begin
                if (commit_kill) q_dat[i].killed    <= 1'b1;
                else             q_dat[i].committed <= 1'b1;
            end
        end
        if (enq) q_dat[wr_ptr] <= new_ent;
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req         <= 1'b0;
            dmem_addr        <= '0;
            dmem_we          <= 1'b0;
            dmem_be          <= '0;
            dmem_wdata       <= '0;
            cur_id           <= '0;
            mem_result_valid <= 1'b0;
            mem_result_id    <= '0;
            mem_result_rdata <= '0;
            mem_result_err   <= 1'b0;
        end else begin
            mem_result_valid <= 1'b0;
            if (issue) begin
                dmem_req   <= 1'b1;
                dmem_addr  <= head.addr;
                dmem_we    <= head.we;
                dmem_be    <= head.be;
                dmem_wdata <= head.wdata;
                cur_id     <= head.id;
            end else if (state == REQ && dmem_gnt) begin
                dmem_req <= 1'b0;
            end
            if (state == WAIT && dmem_rvalid) begin
                mem_result_valid <= 1'b1;
                mem_result_id    <= cur_id;
                mem_result_rdata <= dmem_we ? '0 : dmem_rdata;
                mem_result_err   <= dmem_err;
            end
        end
    end

endmodule

// File: tb/tb_xif_mem_responder.sv
// Directed bench for xif_mem_responder: alignment, speculation/commit/kill, queue backpressure, ordering, reset.
module tb_xif_mem_responder;
    logic        ck = 1'b0;
    logic        rst_n;
    logic        mem_valid;
    logic        mem_ready;
    logic [3:0]  mem_req_id;
    logic [31:0] mem_req_addr;
    logic        mem_req_we;
    logic [2:0]  mem_req_size;
    logic [3:0]  mem_req_be;
    logic [31:0] mem_req_wdata;
    logic        mem_req_spec;
    logic        mem_resp_exc;
    logic [5:0]  mem_resp_exccode;
    logic        commit_valid;
    logic [3:0]  commit_id;
    logic        commit_kill;
    logic        dmem_req;
    logic        dmem_gnt;
    logic [31:0] dmem_addr;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        dmem_err;
    logic        mem_result_valid;
    logic [3:0]  mem_result_id;
    logic [31:0] mem_result_rdata;
    logic        mem_result_err;

    int n_tests = 0;
    int n_fail  = 0;
    int req_cnt = 0;
    int res_cnt = 0;
    int req0;
    int res0;

    always #5 ck = ~ck;

    xif_mem_responder #(.X_ID_WIDTH(4), .X_MEM_WIDTH(32), .QUEUE_DEPTH(2)) dut (
        .ck(ck), .rst_n(rst_n),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_req_id(mem_req_id), .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we),
        .mem_req_size(mem_req_size), .mem_req_be(mem_req_be), .mem_req_wdata(mem_req_wdata),
        .mem_req_spec(mem_req_spec),
        .mem_resp_exc(mem_resp_exc), .mem_resp_exccode(mem_resp_exccode),
        .commit_valid(commit_valid), .commit_id(commit_id), .commit_kill(commit_kill),
        .dmem_req(dmem_req), .dmem_gnt(dmem_gnt), .dmem_addr(dmem_addr), .dmem_we(dmem_we),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .dmem_err(dmem_err),
        .mem_result_valid(mem_result_valid), .mem_result_id(mem_result_id),
        .mem_result_rdata(mem_result_rdata), .mem_result_err(mem_result_err)
    );

    // Activity counters sampled mid-cycle, used to prove the absence of accesses and results.
    always @(negedge ck) begin
        if (dmem_req) req_cnt++;
        if (mem_result_valid) res_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge ck);
        #1;
    endtask

    task automatic clr_in();
        mem_valid    = 1'b0;
        mem_req_spec = 1'b0;
        commit_valid = 1'b0;
        commit_kill  = 1'b0;
        commit_id    = 4'd0;
    endtask

    task automatic put_req(input logic [3:0] id, input logic [31:0] addr, input logic we,
                           input logic [2:0] size, input logic [31:0] wdata, input logic spec);
        mem_valid     = 1'b1;
        mem_req_id    = id;
        mem_req_addr  = addr;
        mem_req_we    = we;
        mem_req_size  = size;
        mem_req_be    = 4'hF;
        mem_req_wdata = wdata;
        mem_req_spec  = spec;
        #1;
    endtask

    task automatic commit(input logic [3:0] id, input logic kill);
        commit_valid = 1'b1;
        commit_id    = id;
        commit_kill  = kill;
    endtask

    // Grants in the current cycle, returns rvalid the next; result is visible on return.
    task automatic serve(input logic [31:0] rdata, input logic err);
        dmem_gnt = 1'b1;
        step();
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        dmem_err    = err;
        step();
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
        dmem_err    = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 20 && !dmem_req; i++) step();
        check(tag, dmem_req, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        clr_in();
        mem_req_id = '0; mem_req_addr = '0; mem_req_we = 1'b0; mem_req_size = '0;
        mem_req_be = '0; mem_req_wdata = '0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0; dmem_err = 1'b0;
        step(); step();
        check("rst_ready", mem_ready, 0);
        check("rst_req", dmem_req, 0);
        check("rst_res_vld", mem_result_valid, 0);
        check("rst_addr", dmem_addr, 0);
        rst_n = 1'b1;
        step();
        check("ready_after_rst", mem_ready, 1);

        // Aligned load, immediate grant: result three cycles after acceptance.
        put_req(4'd3, 32'h100, 1'b0, 3'd2, 32'h0, 1'b0);
        check("ld_exc", mem_resp_exc, 0);
        check("ld_ready", mem_ready, 1);
        step();
        clr_in();
        check("ld_req_t1", dmem_req, 1);
        check("ld_addr", dmem_addr, 32'h100);
        check("ld_we", dmem_we, 0);
        serve(32'h3F80_0000, 1'b0);
        check("ld_res_vld_t3", mem_result_valid, 1);
        check("ld_res_id", mem_result_id, 3);
        check("ld_res_rdata", mem_result_rdata, 32'h3F80_0000);
        check("ld_res_err", mem_result_err, 0);
        step();
        check("ld_res_one_cycle", mem_result_valid, 0);

        // Misaligned requests: exception in the request cycle, never reach memory.
        req0 = req_cnt; res0 = res_cnt;
        put_req(4'd5, 32'h102, 1'b1, 3'd2, 32'h55, 1'b0);
        check("mis_st_exc", mem_resp_exc, 1);
        check("mis_st_code", mem_resp_exccode, 6);
        check("mis_st_ready", mem_ready, 1);
        step();
        put_req(4'd6, 32'h101, 1'b0, 3'd1, 32'h0, 1'b0);
        check("mis_ld_h_exc", mem_resp_exc, 1);
        check("mis_ld_h_code", mem_resp_exccode, 4);
        step();
        put_req(4'd6, 32'h0, 1'b0, 3'd3, 32'h0, 1'b0);
        check("mis_size3_code", mem_resp_exccode, 4);
        step();
        clr_in();
        #1;
        check("exc_idle", mem_resp_exc, 0);
        check("exccode_idle", mem_resp_exccode, 0);
        step(); step(); step();
        check("mis_no_req", req_cnt - req0, 0);
        check("mis_no_res", res_cnt - res0, 0);

        // Speculative load waits for its own commit; a foreign commit does not release it.
        req0 = req_cnt;
        put_req(4'd7, 32'h30, 1'b0, 3'd2, 32'h0, 1'b1);
        step();
        clr_in();
        step(); step();
        commit(4'd2, 1'b0);
        step();
        clr_in();
        step(); step();
        check("spec_held", req_cnt - req0, 0);
        commit(4'd7, 1'b0);
        step();
        clr_in();
        step();
        check("spec_rel_req", dmem_req, 1);
        check("spec_rel_addr", dmem_addr, 32'h30);
        serve(32'h1234_5678, 1'b0);
        check("spec_res_id", mem_result_id, 7);
        check("spec_res_rdata", mem_result_rdata, 32'h1234_5678);

        // Commit in the same cycle as enqueue of that id.
        step();
        put_req(4'd6, 32'h38, 1'b0, 3'd2, 32'h0, 1'b1);
        commit(4'd6, 1'b0);
        step();
        clr_in();
        check("same_cyc_commit_req", dmem_req, 1);
        serve(32'hA5A5_0001, 1'b0);
        check("same_cyc_res_id", mem_result_id, 6);

        // Killed speculative load: dropped silently, the next request still proceeds.
        step();
        req0 = req_cnt; res0 = res_cnt;
        put_req(4'd7, 32'h40, 1'b0, 3'd2, 32'h0, 1'b1);
        step();
        clr_in();
        commit(4'd7, 1'b1);
        step();
        clr_in();
        step(); step(); step();
        check("kill_no_req", req_cnt - req0, 0);
        check("kill_no_res", res_cnt - res0, 0);
        put_req(4'd4, 32'h44, 1'b0, 3'd2, 32'h0, 1'b0);
        step();
        clr_in();
        wait_req("after_kill_req");
        check("after_kill_addr", dmem_addr, 32'h44);
        serve(32'h4444_4444, 1'b0);
        check("after_kill_id", mem_result_id, 4);
        step();

        // Grant withheld: one access in flight plus two queued fills the queue.
        put_req(4'd1, 32'h10, 1'b0, 3'd2, 32'h0, 1'b0);
        check("q_rdy1", mem_ready, 1);
        step();
        put_req(4'd2, 32'h14, 1'b0, 3'd2, 32'h0, 1'b0);
        check("q_rdy2", mem_ready, 1);
        step();
        put_req(4'd3, 32'h18, 1'b1, 3'd2, 32'hCAFE_F00D, 1'b0);
        check("q_rdy3", mem_ready, 1);
        step();
        put_req(4'd4, 32'h1C, 1'b0, 3'd2, 32'h0, 1'b0);
        check("q_full_rdy", mem_ready, 0);
        step(); step();
        check("q_full_rdy_hold", mem_ready, 0);
        check("q_req_stable", dmem_req, 1);
        check("q_addr_stable", dmem_addr, 32'h10);
        serve(32'h1111_1111, 1'b0);
        check("q_res1_id", mem_result_id, 1);
        check("q_res1_rdata", mem_result_rdata, 32'h1111_1111);
        #1;
        check("q_pop_cycle_rdy", mem_ready, 0);
        step();
        check("q_rdy_after_pop", mem_ready, 1);
        check("q_req2", dmem_req, 1);
        check("q_addr2", dmem_addr, 32'h14);
        step();
        clr_in();
        serve(32'h2222_2222, 1'b1);
        check("q_res2_id", mem_result_id, 2);
        check("q_res2_err", mem_result_err, 1);
        wait_req("q_req3");
        check("q_st_we", dmem_we, 1);
        check("q_st_wdata", dmem_wdata, 32'hCAFE_F00D);
        serve(32'hDEAD_BEEF, 1'b0);
        check("q_res3_id", mem_result_id, 3);
        check("q_res3_st_rdata", mem_result_rdata, 0);
        wait_req("q_req4");
        check("q_addr4", dmem_addr, 32'h1C);
        serve(32'h4040_4040, 1'b0);
        check("q_res4_id", mem_result_id, 4);
        step();

        // Reset during WAIT with a speculative entry queued behind it.
        put_req(4'd8, 32'h50, 1'b0, 3'd2, 32'h0, 1'b0);
        step();
        clr_in();
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        put_req(4'd9, 32'h54, 1'b0, 3'd2, 32'h0, 1'b1);
        step();
        clr_in();
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", dmem_req, 0);
        check("mid_rst_addr", dmem_addr, 0);
        check("mid_rst_res_vld", mem_result_valid, 0);
        check("mid_rst_ready", mem_ready, 0);
        step();
        rst_n = 1'b1;
        req0 = req_cnt; res0 = res_cnt;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h9999_9999;
        step();
        dmem_rvalid = 1'b0;
        commit(4'd9, 1'b0);
        step();
        clr_in();
        step(); step(); step();
        check("late_rvalid_no_res", res_cnt - res0, 0);
        check("rst_queue_empty", req_cnt - req0, 0);
        check("post_rst_ready", mem_ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
